// File: rtl/jt51_noise_sched.sv
// Noise channel scheduler: divides the frame rate down to an LFSR shift
// strobe, captures the post-shift noise bit and produces a signed,
// envelope-scaled noise sample once per frame at slot 31.
module jt51_noise_sched (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        zero,
    input  logic [4:0]  cycles,
    input  logic        ne,
    input  logic [4:0]  nfrq,
    input  logic [9:0]  eg,
    input  logic        lfsr_bit,
    output logic        base,
    output logic [11:0] out,
    output logic        out_valid
);

    logic [4:0]  cnt;
    logic [4:0]  term;
    logic        fire;
    logic        cap;
    logic        nbit;
    logic        upd;
    logic [9:0]  amp;
    logic [11:0] amp_pos;
    logic [11:0] out_next;

    // Divider terminal and fire decision; >= (not ==) so a lowered term
    // mid-count fires on the next strobe instead of wrapping through 31.
    always_comb begin
        term = ~nfrq;
        fire = zero && (cnt >= term);
    end

    // Output sample selection: +amp, -amp or silence when noise is off.
    always_comb begin
        upd     = (cycles == 5'd31);
        amp     = 10'd1023 - eg;
        amp_pos = {2'b00, amp};
        out_next = 12'd0;
        if (ne) begin
            out_next = nbit ? amp_pos : (12'd0 - amp_pos);
        end
    end

    // Frame counter: advances once per zero strobe, reloads on fire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 5'd0;
        end else if (cen && zero) begin
            cnt <= fire ? 5'd0 : cnt + 5'd1;
        end
    end

    // Shift strobe, then a one-cen delayed capture of the shifted LFSR bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base <= 1'b0;
            cap  <= 1'b0;
            nbit <= 1'b0;
        end else if (cen) begin
            base <= fire;
            cap  <= base;
            if (cap) begin
                nbit <= lfsr_bit;
            end
        end
    end

    // Sample register: nonblocking update uses nbit from before any capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= 12'd0;
            out_valid <= 1'b0;
        end else if (cen) begin
            out_valid <= upd;
            if (upd) begin
                out <= out_next;
            end
        end
    end

endmodule

// File: tb/tb_jt51_noise_sched.sv
// Randomized bench for jt51_noise_sched with a frame-level reference model
// and directed scenarios for divider timing, output scaling and reset.
module tb_jt51_noise_sched;

    logic        rst = 1'b1;
    logic        clk = 1'b0;
    logic        cen = 1'b0;
    logic        zero = 1'b0;
    logic [4:0]  cycles = 5'd0;
    logic        ne = 1'b1;
    logic [4:0]  nfrq = 5'd31;
    logic [9:0]  eg = 10'd0;
    logic        lfsr_bit = 1'b0;
    logic        base;
    logic [11:0] out;
    logic        out_valid;

    jt51_noise_sched dut (
        .rst       (rst),
        .clk       (clk),
        .cen       (cen),
        .zero      (zero),
        .cycles    (cycles),
        .ne        (ne),
        .nfrq      (nfrq),
        .eg        (eg),
        .lfsr_bit  (lfsr_bit),
        .base      (base),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // stimulus controls
    int slot = 0;
    int zslot = 0;
    int zcount = 0;
    int zbase = 0;
    bit full_cen = 1'b0;
    bit eg_rand = 1'b0;
    int lfsr_mode = 0;  // 0 random, 1 held high, 2 held low
    bit rst_hold = 1'b0;
    bit rst_on_zero = 1'b0;
    int pulses[$];

    // reference model state
    int m_since;   // zero strobes counted since the last shift (or reset)
    bit m_base;
    bit m_cap;
    bit m_nbit;
    int m_out;
    bit m_ov;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_since = 0;
        m_base  = 1'b0;
        m_cap   = 1'b0;
        m_nbit  = 1'b0;
        m_out   = 0;
        m_ov    = 1'b0;
    endtask

    // One enabled clock: shift period is (32 - nfrq) strobes, the bit is
    // taken one cycle after the strobe, output built from the held bit.
    task automatic model_edge();
        bit shift_now;
        shift_now = zero && (m_since >= 31 - int'(nfrq));
        if (zero) m_since = shift_now ? 0 : m_since + 1;
        if (cycles == 5'd31) begin
            if (!ne) m_out = 0;
            else if (m_nbit) m_out = 1023 - int'(eg);
            else m_out = int'(eg) - 1023;
        end
        m_ov = (cycles == 5'd31);
        if (m_cap) m_nbit = lfsr_bit;
        m_cap  = m_base;
        m_base = shift_now;
    endtask

    task automatic step();
        @(negedge clk);
        rst = rst_hold;
        if (rst_on_zero && slot == zslot) begin
            rst = 1'b1;
            rst_on_zero = 1'b0;
        end
        cen    = full_cen ? 1'b1 : ($urandom_range(0, 3) != 0);
        zero   = (slot == zslot);
        cycles = 5'(slot);
        case (lfsr_mode)
            1: lfsr_bit = 1'b1;
            2: lfsr_bit = 1'b0;
            default: lfsr_bit = 1'($urandom_range(0, 1));
        endcase
        if (eg_rand && $urandom_range(0, 15) == 0) eg = 10'($urandom_range(0, 1023));
        if (cen && base && !rst) pulses.push_back(zcount - zbase);
        @(posedge clk);
        if (rst) model_reset();
        else if (cen) model_edge();
        if (cen) begin
            if (zero && !rst) zcount++;
            slot = (slot + 1) % 32;
        end
        #1;
        check("base", int'(base), int'(m_base));
        check("out", int'($signed(out)), m_out);
        check("out_valid", int'(out_valid), int'(m_ov));
        if (rst) begin
            check("rst_base", int'(base), 0);
            check("rst_out", int'(out), 0);
            check("rst_valid", int'(out_valid), 0);
        end
    endtask

    task automatic do_reset();
        rst_hold = 1'b1;
        repeat (3) step();
        rst_hold = 1'b0;
        pulses.delete();
        zbase = zcount;
    endtask

    task automatic run_strobes(input int n);
        int target;
        int guard;
        int cens;
        target = zcount + n;
        guard = 0;
        while (zcount < target && guard < n * 200 + 200) begin
            step();
            guard++;
        end
        if (zcount < target) check("strobe_timeout", 0, 1);
        cens = 0;
        guard = 0;
        while (cens < 2 && guard < 100) begin
            step();
            if (cen) cens++;
            guard++;
        end
    endtask

    function automatic int pulse_at(input int i);
        return (i < pulses.size()) ? pulses[i] : -1;
    endfunction

    task automatic check_gaps(input string tag, input int gap);
        for (int i = 1; i < pulses.size(); i++) begin
            check(tag, pulses[i] - pulses[i-1], gap);
        end
    endtask

    int saved[$];

    initial begin
        model_reset();
        do_reset();
        check("reset_base", int'(base), 0);
        check("reset_out", int'(out), 0);

        // one shift per frame at the fastest setting
        full_cen = 1'b1;
        nfrq = 5'd31;
        ne = 1'b1;
        eg = 10'd0;
        run_strobes(10);
        check("n_pulses_nfrq31", pulses.size(), 10);
        check("first_nfrq31", pulse_at(0), 1);

        // full-scale output in both signs, then silence at max attenuation
        lfsr_mode = 1;
        run_strobes(3);
        check("out_pos", int'(out), 12'h3FF);
        lfsr_mode = 2;
        run_strobes(3);
        check("out_neg", int'(out), 12'hC01);
        eg = 10'd1023;
        run_strobes(2);
        check("out_silent", int'(out), 0);
        lfsr_mode = 0;
        full_cen = 1'b0;
        eg_rand = 1'b1;

        // slowest and mid-range periods
        do_reset();
        nfrq = 5'd0;
        run_strobes(70);
        check("first_nfrq0", pulse_at(0), 32);
        check("n_pulses_nfrq0", pulses.size(), 2);
        check_gaps("gap_nfrq0", 32);
        do_reset();
        nfrq = 5'd16;
        run_strobes(50);
        check("first_nfrq16", pulse_at(0), 16);
        check_gaps("gap_nfrq16", 16);

        // lowering the period below the running count fires immediately
        do_reset();
        nfrq = 5'd0;
        run_strobes(20);
        check("none_before_change", pulses.size(), 0);
        nfrq = 5'd20;
        run_strobes(30);
        check("first_after_change", pulse_at(0), 21);
        check("n_after_change", pulses.size(), 3);
        check_gaps("gap_nfrq20", 12);

        // noise disabled: identical shift timing, silent output
        do_reset();
        nfrq = 5'd28;
        ne = 1'b1;
        run_strobes(20);
        saved = pulses;
        do_reset();
        ne = 1'b0;
        eg = 10'd0;
        eg_rand = 1'b0;
        run_strobes(20);
        check("ne_off_count", pulses.size(), saved.size());
        for (int i = 0; i < saved.size(); i++) check("ne_off_timing", pulse_at(i), saved[i]);
        check("ne_off_out", int'(out), 0);
        ne = 1'b1;
        eg_rand = 1'b1;

        // reset landing on the strobe that would shift
        do_reset();
        full_cen = 1'b1;
        nfrq = 5'd31;
        run_strobes(2);
        rst_on_zero = 1'b1;
        for (int i = 0; i < 100 && rst_on_zero; i++) step();
        check("rst_taken", int'(rst_on_zero), 0);
        step();
        check("rst_no_pulse", int'(base), 0);
        pulses.delete();
        zbase = zcount;
        run_strobes(1);
        check("first_after_rst", pulse_at(0), 1);
        full_cen = 1'b0;

        // strobe coinciding with slot 31, then random soak
        zslot = 31;
        for (int it = 0; it < 160; it++) begin
            if ($urandom_range(0, 3) == 0) nfrq = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) ne = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) zslot = $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) rst_on_zero = 1'b1;
            run_strobes(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/jt51_noise_sched.md
JT51_NOISE_SCHED -- requirements
Module: jt51_noise_sched

Interface
REQ-001 The block SHALL have no parameters; all timing SHALL be fixed by REQ-010 to REQ-014.
REQ-002 The block SHALL have these ports, clock and reset first:
- rst  in  1  reset; asynchronous, active-high
- clk  in  1  clock
- cen  in  1  clock enable; no state changes when low
- zero  in  1  sample-period strobe; high for one cen cycle per 32-slot frame
- cycles  in  5  current slot number, 0..31
- ne  in  1  noise enable, from register 0Fh bit 7
- nfrq  in  5  noise frequency, from register 0Fh bits 4:0
- eg  in  10  envelope attenuation for slot 31; 0 = loudest, 1023 = silent
- lfsr_bit  in  1  current output bit of the noise LFSR
- base  out  1  shift strobe to the noise LFSR
- out  out  12  signed two's-complement noise sample
- out_valid  out  1  one-cen-cycle pulse when out is updated

Function
REQ-010 Frequency divider:
- 5-bit counter cnt advances only when cen and zero are both high.
- Terminal value term = ~nfrq (that is, 31 - nfrq).
- On a zero cycle with cnt >= term: cnt SHALL load 0 and base SHALL be asserted.
- On any other zero cycle: cnt SHALL increment by 1, with no wrap beyond 31.
REQ-011 base SHALL be a registered output. It SHALL be high for exactly the single cen cycle that follows the qualifying zero cycle, and low at all other times.
REQ-012 LFSR shift period SHALL be (32 - nfrq) frames:
- nfrq = 31 gives a base pulse every frame.
- nfrq = 0 gives a base pulse every 32 frames.
REQ-013 If nfrq changes mid-count so that cnt >= the new term, base SHALL fire on the next zero cycle. There SHALL be no wrap through 31 and no lost pulse.
REQ-014 Bit capture: the first cen cycle after a cen cycle with base high SHALL sample lfsr_bit into register nbit. nbit therefore holds the post-shift LFSR bit.
REQ-015 Amplitude SHALL be amp = 1023 - eg, unsigned 10 bits, never negative.
REQ-016 Output update:
- On a cen cycle with cycles == 31, out SHALL load +amp when nbit = 1 and -amp when nbit = 0.
- Both values SHALL be sign-extended to 12 bits, giving range -1023..+1023.
- out_valid SHALL be high on the following cen cycle only.
REQ-017 When ne = 0:
- out SHALL load 0 at each slot-31 update, and out_valid SHALL still pulse.
- The divider and base generation SHALL keep running, so the LFSR phase is unaffected by ne.
REQ-018 Changes to eg or nbit between updates SHALL NOT alter out until the next slot-31 update.
REQ-019 When cen is low, all registers SHALL hold, including pending base, nbit capture and out_valid.
REQ-020 If zero and cycles == 31 coincide in one cen cycle, both actions SHALL occur. The output update SHALL use the nbit value from before the capture.

Reset
REQ-030 While rst is high: cnt = 0, base = 0, nbit = 0, out = 0, out_valid = 0.
REQ-031 Reset asserted mid-count SHALL abort any pending base pulse or capture; no pulse SHALL appear after release.
REQ-032 After rst is released, the first base pulse SHALL occur (32 - nfrq) zero strobes later, counting from the first zero strobe.

Verification
REQ-040 nfrq = 31, ne = 1, 10 frames -> 10 base pulses, one per frame, each 1 cen cycle wide.
REQ-041 nfrq = 0 -> base pulses exactly 32 frames apart; nfrq = 16 -> pulses exactly 16 frames apart.
REQ-042 cnt = 20 with nfrq = 0, then nfrq changed to 20 (term = 11) -> base fires on the very next zero strobe, and the following pulses are 12 frames apart.
REQ-043 eg = 0 with lfsr_bit held 1 -> out = +1023 (12'h3FF); lfsr_bit held 0 -> out = -1023 (12'hC01); eg = 1023 -> out = 0.
REQ-044 ne = 0 with eg = 0 -> out = 0 and out_valid pulses every frame; base timing is identical to the ne = 1 run.
REQ-045 rst pulsed on the zero cycle that would fire base -> no base pulse and all outputs 0; with nfrq = 31, the first base follows the first zero strobe after release.
